ex_mem_skid_reg: RTL and testbench

//  EX->MEM pipeline stage sitting directly downstream of the ALU.
//  - Captures the ALU outputs and the destination-register info.
//  - Merges the compare flag into the result for SLT/SLTU.
//  - Presents one registered, valid/ready-handshaked result per cycle to the memory stage.
//  - 2-entry skid buffer, so in_ready is a pure register output.

---
 rtl/ex_mem_skid_reg.sv | 201 ++++++++++++++++++++
 tb/tb_ex_mem_skid_reg.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer.
// Captures ALU results, merges SLT/SLTU compare flags into the data,
// and hands one result per cycle to MEM over a valid/ready handshake.
// in_ready and out_valid come straight from flops.
//
// Ports:
//   clk, rst           clock (rising), async active-high reset
//   in_valid/in_ready  upstream handshake from EX
//   alu_res/cout/cmp   ALU outputs, alu_ctrl selects the merge
//   rd_addr, rd_we     destination register info
//   flush              synchronous squash of all held results
//   out_valid/ready    downstream handshake to MEM
//   out_data/zero      merged result and its zero flag
//   out_rd_addr/we     destination register, we forced 0 for x0
//   out_cout           only when EX_MEM_COUT_EN is defined
//
// Optional feature macro: EX_MEM_COUT_EN (carries alu_cout to out_cout).

module ex_mem_skid_reg #(
    parameter int N    = 4,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    alu_res,
    input  logic            alu_cout,
    input  logic            alu_cmp,
    input  logic [3:0]      alu_ctrl,
    input  logic [RA_W-1:0] rd_addr,
    input  logic            rd_we,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic            out_zero,
    output logic [RA_W-1:0] out_rd_addr,
    output logic            out_rd_we
`ifdef EX_MEM_COUT_EN
    ,
    output logic            out_cout
`endif
);

    localparam logic [3:0] CTRL_SLT  = 4'b1000;
    localparam logic [3:0] CTRL_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic            in_fire;
    logic            out_fire;
    logic            load_in;
    logic            load_skid;
    logic            skid_to_out;

    logic            is_cmp;
    logic [N-1:0]    cap_data;
    logic            cap_zero;
    logic            cap_we;

    logic [N-1:0]    skid_data;
    logic            skid_zero;
    logic [RA_W-1:0] skid_rd_addr;
    logic            skid_rd_we;

`ifdef EX_MEM_COUT_EN
    logic            cap_cout;
    logic            skid_cout;
`else
    logic            unused_cout;
    assign unused_cout = alu_cout;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Result merge applied at capture time
    always_comb begin
        is_cmp   = (alu_ctrl == CTRL_SLT) || (alu_ctrl == CTRL_SLTU);
        cap_data = alu_res;
        if (is_cmp) begin
            cap_data    = '0;
            cap_data[0] = alu_cmp;
        end
        cap_zero = (cap_data == '0);
        cap_we   = rd_we & (rd_addr != '0);
`ifdef EX_MEM_COUT_EN
        cap_cout = is_cmp ? 1'b0 : alu_cout;
`endif
    end

    // Occupancy FSM: next state and datapath load strobes
    always_comb begin
        state_d     = state_q;
        load_in     = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        load_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d     = ONE;
                        skid_to_out = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State plus handshake flops, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
        end
    end

    // Output and skid entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data     <= '0;
            out_zero     <= 1'b0;
            out_rd_addr  <= '0;
            out_rd_we    <= 1'b0;
            skid_data    <= '0;
            skid_zero    <= 1'b0;
            skid_rd_addr <= '0;
            skid_rd_we   <= 1'b0;
`ifdef EX_MEM_COUT_EN
            out_cout     <= 1'b0;
            skid_cout    <= 1'b0;
`endif
        end else if (flush) begin
            // Data may go stale; only the write enables are squashed
            out_rd_we  <= 1'b0;
            skid_rd_we <= 1'b0;
        end else begin
            if (load_in) begin
                out_data    <= cap_data;
                out_zero    <= cap_zero;
                out_rd_addr <= rd_addr;
                out_rd_we   <= cap_we;
`ifdef EX_MEM_COUT_EN
                out_cout    <= cap_cout;
`endif
            end else if (skid_to_out) begin
                out_data    <= skid_data;
                out_zero    <= skid_zero;
                out_rd_addr <= skid_rd_addr;
                out_rd_we   <= skid_rd_we;
`ifdef EX_MEM_COUT_EN
                out_cout    <= skid_cout;
`endif
            end
            if (load_skid) begin
                skid_data    <= cap_data;
                skid_zero    <= cap_zero;
                skid_rd_addr <= rd_addr;
                skid_rd_we   <= cap_we;
`ifdef EX_MEM_COUT_EN
                skid_cout    <= cap_cout;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg (N=4, RA_W=5).
// Directed stimulus pushes expected items; a monitor pops on transfers.

module tb_ex_mem_skid_reg;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] alu_res;
    logic       alu_cout;
    logic       alu_cmp;
    logic [3:0] alu_ctrl;
    logic [4:0] rd_addr;
    logic       rd_we;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_zero;
    logic [4:0] out_rd_addr;
    logic       out_rd_we;
`ifdef EX_MEM_COUT_EN
    logic       out_cout;
`endif

    typedef struct packed {
        logic [3:0] data;
        logic       zero;
        logic [4:0] rd;
        logic       we;
    } exp_t;

    exp_t q[$];
    int   cmp_n;
    int   fail_n;

    ex_mem_skid_reg #(.N(4), .RA_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .alu_cmp    (alu_cmp),
        .alu_ctrl   (alu_ctrl),
        .rd_addr    (rd_addr),
        .rd_we      (rd_we),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_rd_addr(out_rd_addr),
        .out_rd_we  (out_rd_we)
`ifdef EX_MEM_COUT_EN
        ,
        .out_cout   (out_cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        cmp_n++;
        if (act !== req) begin
            fail_n++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] res, input logic cmp,
                          input logic [3:0] ctrl, input logic [4:0] rd,
                          input logic we);
        alu_res  = res;
        alu_cmp  = cmp;
        alu_ctrl = ctrl;
        rd_addr  = rd;
        rd_we    = we;
        alu_cout = 1'b1;
        in_valid = 1'b1;
    endtask

    // Offer one item, wait for acceptance, record its expected image
    task automatic offer(input logic [3:0] res, input logic cmp,
                         input logic [3:0] ctrl, input logic [4:0] rd,
                         input logic we, input exp_t e);
        int n;
        n = 0;
        set_in(res, cmp, ctrl, rd, we);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            cmp_n++;
            fail_n++;
            $display("FAIL accept_timeout act=in_ready0 req=in_ready1");
        end else begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pop on every out transfer, check stability while stalled
    initial begin : monitor
        exp_t cur;
        exp_t snap;
        exp_t e;
        logic held;
        held = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            cur = {out_data, out_zero, out_rd_addr, out_rd_we};
            if (!rst && out_valid) begin
                if (out_ready) begin
                    cmp_n++;
                    if (q.size() == 0) begin
                        fail_n++;
                        $display("FAIL unexpected_out act=%h req=none", cur);
                    end else begin
                        e = q.pop_front();
                        if (cur !== e) begin
                            fail_n++;
                            $display("FAIL out_item act=%h req=%h t=%0t",
                                     cur, e, $time);
                        end
                    end
                    held = 1'b0;
                end else begin
                    if (held) begin
                        cmp_n++;
                        if (cur !== snap) begin
                            fail_n++;
                            $display("FAIL stall_stable act=%h req=%h",
                                     cur, snap);
                        end
                    end
                    held = 1'b1;
                    snap = cur;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin : stim
        cmp_n     = 0;
        fail_n    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(4'h0, 1'b0, 4'h0, 5'd0, 1'b0);
        in_valid  = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_rd_we", 32'(out_rd_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency and merge cases
        out_ready = 1'b1;
        offer(4'hA, 1'b0, 4'b0000, 5'd3, 1'b1, {4'hA, 1'b0, 5'd3, 1'b1});
        @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data", 32'(out_data), 32'hA);
        @(posedge clk);
        #1;
        offer(4'h0, 1'b1, 4'b1001, 5'd5, 1'b1, {4'h1, 1'b0, 5'd5, 1'b1});
        offer(4'h7, 1'b0, 4'b1000, 5'd6, 1'b1, {4'h0, 1'b1, 5'd6, 1'b1});
        offer(4'h0, 1'b1, 4'b0010, 5'd0, 1'b1, {4'h0, 1'b1, 5'd0, 1'b0});
        offer(4'hF, 1'b1, 4'b0001, 5'd31, 1'b0, {4'hF, 1'b0, 5'd31, 1'b0});
        offer(4'h6, 1'b1, 4'b1010, 5'd9, 1'b1, {4'h6, 1'b0, 5'd9, 1'b1});
        idle(3);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: 1 and 2 accepted, 3 held upstream
        out_ready = 1'b0;
        offer(4'h1, 1'b0, 4'b0000, 5'd1, 1'b1, {4'h1, 1'b0, 5'd1, 1'b1});
        offer(4'h2, 1'b0, 4'b0000, 5'd2, 1'b1, {4'h2, 1'b0, 5'd2, 1'b1});
        set_in(4'h3, 1'b0, 4'b0000, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_gap0", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_gap1", 32'(out_valid), 32'd1);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        q.push_back({4'h3, 1'b0, 5'd4, 1'b1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_gap2", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush coinciding with an out transfer
        @(posedge clk);
        #1;
        offer(4'h9, 1'b0, 4'b0000, 5'd7, 1'b1, {4'h9, 1'b0, 5'd7, 1'b1});
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flx_out_valid", 32'(out_valid), 32'd0);
        chk("flx_q_empty", 32'(q.size()), 32'd0);

        // Flush while FULL with a third input offered
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        offer(4'h5, 1'b0, 4'b0000, 5'd8, 1'b1, {4'h5, 1'b0, 5'd8, 1'b1});
        offer(4'h6, 1'b0, 4'b0000, 5'd8, 1'b1, {4'h6, 1'b0, 5'd8, 1'b1});
        set_in(4'h7, 1'b0, 4'b0000, 5'd8, 1'b1);
        flush = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_out_rd_we", 32'(out_rd_we), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);

        // Async reset mid-stream from FULL
        out_ready = 1'b0;
        offer(4'hC, 1'b0, 4'b0000, 5'd2, 1'b1, {4'hC, 1'b0, 5'd2, 1'b1});
        offer(4'hD, 1'b0, 4'b0000, 5'd2, 1'b1, {4'hD, 1'b0, 5'd2, 1'b1});
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_zero", 32'(out_zero), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        offer(4'h4, 1'b0, 4'b0011, 5'd10, 1'b1, {4'h4, 1'b0, 5'd10, 1'b1});
        idle(4);
        chk("final_q_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, fail_n);
        $finish;
    end

endmodule
